// File: rtl/iter_alu_if.sv
// Handshake bundle between decode, the iterative execute unit and writeback.
// master = issuing/consuming side, slave = iter_alu.
interface iter_alu_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            branch;
  logic            illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, branch, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, branch, illegal
  );
endinterface

// File: rtl/iter_alu.sv
// Multi-cycle RV32I-class execute unit: single-cycle ALU/branch ops, iterative shifts.
// Define ITER_ALU_MUL_EN to add op 16 (MUL) as a 1-bit/cycle shift-add multiplier.
module iter_alu #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic       clk,
  input  logic       rst,
  iter_alu_if.slave  bus
);

  localparam int unsigned ShW = $clog2(XLEN);
  // Remaining shift is always < XLEN, so capping the step there keeps it in ShW bits.
  localparam int unsigned  StepCap = (SHIFT_STEP >= XLEN) ? (XLEN - 1) : SHIFT_STEP;
  localparam logic [ShW-1:0] StepC = ShW'(StepCap);

  localparam logic [4:0] OpAdd  = 5'd0;
  localparam logic [4:0] OpSub  = 5'd1;
  localparam logic [4:0] OpXor  = 5'd2;
  localparam logic [4:0] OpOr   = 5'd3;
  localparam logic [4:0] OpAnd  = 5'd4;
  localparam logic [4:0] OpSll  = 5'd5;
  localparam logic [4:0] OpSrl  = 5'd6;
  localparam logic [4:0] OpSra  = 5'd7;
  localparam logic [4:0] OpSlt  = 5'd8;
  localparam logic [4:0] OpSltu = 5'd9;
  localparam logic [4:0] OpBeq  = 5'd10;
  localparam logic [4:0] OpBne  = 5'd11;
  localparam logic [4:0] OpBlt  = 5'd12;
  localparam logic [4:0] OpBge  = 5'd13;
  localparam logic [4:0] OpBltu = 5'd14;
  localparam logic [4:0] OpBgeu = 5'd15;
`ifdef ITER_ALU_MUL_EN
  localparam logic [4:0] OpMul  = 5'd16;
`endif

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
`ifdef ITER_ALU_MUL_EN
    ,
    StMul   = 2'd3
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            branch_q, branch_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [ShW-1:0]  rem_q, rem_d;
  logic [1:0]      kind_q, kind_d;
`ifdef ITER_ALU_MUL_EN
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] mul_sum;
  logic [XLEN-1:0] mplier_shr;
`endif

  // Single-cycle datapath, evaluated on the issue-side operands.
  logic [XLEN-1:0] alu_res;
  logic            alu_br;
  logic            alu_ill;
  logic            is_shift;
  logic            is_mul;
  logic            lt_s;
  logic            lt_u;
  logic            eq;
  logic [ShW-1:0]  shamt;

  assign lt_s  = $signed(bus.a) < $signed(bus.b);
  assign lt_u  = bus.a < bus.b;
  assign eq    = bus.a == bus.b;
  assign shamt = bus.b[ShW-1:0];

  always_comb begin
    alu_res  = '0;
    alu_br   = 1'b0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    is_mul   = 1'b0;
    case (bus.op)
      OpAdd:  alu_res = bus.a + bus.b;
      OpSub:  alu_res = bus.a - bus.b;
      OpXor:  alu_res = bus.a ^ bus.b;
      OpOr:   alu_res = bus.a | bus.b;
      OpAnd:  alu_res = bus.a & bus.b;
      OpSll, OpSrl, OpSra: begin
        is_shift = 1'b1;
        alu_res  = bus.a;
      end
      OpSlt:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OpSltu: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      OpBeq:  alu_br  = eq;
      OpBne:  alu_br  = ~eq;
      OpBlt:  alu_br  = lt_s;
      OpBge:  alu_br  = ~lt_s;
      OpBltu: alu_br  = lt_u;
      OpBgeu: alu_br  = ~lt_u;
`ifdef ITER_ALU_MUL_EN
      OpMul:  is_mul  = 1'b1;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  // Iterative shifter: one step of min(SHIFT_STEP, remaining) per cycle.
  logic [ShW-1:0]  step;
  logic [ShW-1:0]  rem_dec;
  logic [XLEN-1:0] shifted;

  always_comb begin
    step    = (rem_q < StepC) ? rem_q : StepC;
    rem_dec = rem_q - step;
    case (kind_q)
      2'b01:   shifted = acc_q << step;
      2'b10:   shifted = acc_q >> step;
      default: shifted = XLEN'($signed(acc_q) >>> step);
    endcase
  end

`ifdef ITER_ALU_MUL_EN
  assign mul_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mplier_shr = mplier_q >> 1;
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    branch_d  = branch_q;
    illegal_d = illegal_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    kind_d    = kind_q;
`ifdef ITER_ALU_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (is_shift && (shamt != '0)) begin
            state_d = StShift;
            acc_d   = bus.a;
            rem_d   = shamt;
            kind_d  = bus.op[1:0];
`ifdef ITER_ALU_MUL_EN
          end else if (is_mul) begin
            state_d  = StMul;
            acc_d    = '0;
            mcand_d  = bus.a;
            mplier_d = bus.b;
`endif
          end else begin
            state_d   = StDone;
            result_d  = alu_res;
            branch_d  = alu_br;
            illegal_d = alu_ill;
          end
        end
      end
      StShift: begin
        acc_d = shifted;
        rem_d = rem_dec;
        if (rem_dec == '0) begin
          state_d   = StDone;
          result_d  = shifted;
          branch_d  = 1'b0;
          illegal_d = 1'b0;
        end
      end
`ifdef ITER_ALU_MUL_EN
      StMul: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shr;
        // Stop as soon as no multiplier bits remain; bounds the loop at XLEN cycles.
        if (mplier_shr == '0) begin
          state_d   = StDone;
          result_d  = mul_sum;
          branch_d  = 1'b0;
          illegal_d = 1'b0;
        end
      end
`endif
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      result_q  <= '0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
      acc_q     <= '0;
      rem_q     <= '0;
      kind_q    <= '0;
`ifdef ITER_ALU_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      kind_q    <= kind_d;
`ifdef ITER_ALU_MUL_EN
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.branch    = branch_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: driver pushes model results, negedge monitor pops and compares.
module tb_iter_alu;
  localparam int unsigned XLEN = 32;
  localparam int unsigned STEP = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iter_alu_if #(.XLEN(XLEN)) bus ();

  iter_alu #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        br;
    logic        ill;
    int          lat_min;
    int          lat_max;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   hold_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: the ISA rules written with plain SV arithmetic.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    int   sh;
    sh        = int'(b[4:0]);
    e.res     = '0;
    e.br      = 1'b0;
    e.ill     = 1'b0;
    e.lat_min = 1;
    e.lat_max = 1;
    e.acc     = 0;
    case (op)
      5'd0:  e.res = a + b;
      5'd1:  e.res = a - b;
      5'd2:  e.res = a ^ b;
      5'd3:  e.res = a | b;
      5'd4:  e.res = a & b;
      5'd5:  e.res = a << sh;
      5'd6:  e.res = a >> sh;
      5'd7:  e.res = $signed(a) >>> sh;
      5'd8:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd9:  e.res = (a < b) ? 32'd1 : 32'd0;
      5'd10: e.br  = (a == b);
      5'd11: e.br  = (a != b);
      5'd12: e.br  = ($signed(a) < $signed(b));
      5'd13: e.br  = ($signed(a) >= $signed(b));
      5'd14: e.br  = (a < b);
      5'd15: e.br  = (a >= b);
`ifdef ITER_ALU_MUL_EN
      5'd16: begin
        e.res     = a * b;
        e.lat_min = 2;
        e.lat_max = XLEN + 1;
      end
`endif
      default: e.ill = 1'b1;
    endcase
    if (op >= 5'd5 && op <= 5'd7 && sh != 0) begin
      e.lat_min = (sh + STEP - 1) / STEP + 1;
      e.lat_max = e.lat_min;
    end
    return e;
  endfunction

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   waited;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    waited       = 0;
    while (!bus.in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, required 1", waited);
      bus.in_valid = 1'b0;
      return;
    end
    e     = model(op, a, b);
    e.acc = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
  endtask

  // Monitor: compares every cycle out_valid is high (covers hold stability) and owns out_ready.
  bit   in_txn   = 1'b0;
  bit   exp_idle = 1'b0;
  int   hold_cnt = 0;
  exp_t cur;
  int   lat;

  always @(negedge clk) begin
    if (rst) begin
      in_txn        = 1'b0;
      exp_idle      = 1'b0;
      hold_cnt      = 0;
      bus.out_ready = 1'b0;
    end else begin
      if (exp_idle) begin
        chk("in_ready_after_drain", 64'(bus.in_ready), 64'd1);
        exp_idle = 1'b0;
      end
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid: out_valid=1 with empty scoreboard, required 0");
        end else begin
          cur = sb_q[0];
          if (!in_txn) begin
            in_txn = 1'b1;
            lat    = cyc - cur.acc;
            checks++;
            if (lat < cur.lat_min || lat > cur.lat_max) begin
              failures++;
              $display("FAIL latency: got %0d cycles, required %0d..%0d", lat, cur.lat_min,
                       cur.lat_max);
            end
            if (hold_req > 0) begin
              hold_cnt = hold_req;
              hold_req = 0;
            end
          end
          chk("result", 64'(bus.result), 64'(cur.res));
          chk("branch", 64'(bus.branch), 64'(cur.br));
          chk("illegal", 64'(bus.illegal), 64'(cur.ill));
          chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
        end
      end
      if (hold_cnt > 0) begin
        bus.out_ready = 1'b0;
        hold_cnt--;
      end else begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      if (bus.out_valid && bus.out_ready && sb_q.size() != 0) begin
        void'(sb_q.pop_front());
        in_txn   = 1'b0;
        exp_idle = 1'b1;
      end
    end
  end

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.op       = '0;
    bus.a        = '0;
    bus.b        = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_branch", 64'(bus.branch), 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(5'd0, 32'hFFFF_FFFF, 32'd1);
    issue(5'd1, 32'd0, 32'd1);
    issue(5'd8, 32'hFFFF_FFFF, 32'd1);
    issue(5'd9, 32'hFFFF_FFFF, 32'd1);
    issue(5'd7, 32'h8000_0000, 32'd31);
    issue(5'd7, 32'h8000_0000, 32'd0);
    issue(5'd12, 32'hFFFF_FFFB, 32'd3);
    issue(5'd15, 32'hFFFF_FFFB, 32'd3);
    issue(5'd10, 32'd7, 32'd7);
    issue(5'd11, 32'd7, 32'd7);
    issue(5'd16, 32'h0000_FFFF, 32'h0001_0001);
    issue(5'd16, 32'h1234_5678, 32'd0);
    issue(5'd20, 32'h1234_5678, 32'h9ABC_DEF0);
    issue(5'd5, 32'h0000_0001, 32'hFFFF_FFE3);
    wait_empty();

    hold_req = 5;
    issue(5'd2, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    wait_empty();

    // Reset in the middle of a 20-step shift must abort with no result.
    issue(5'd5, 32'd1, 32'd20);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_result", 64'(bus.result), 64'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("midrst_no_result", 64'(bus.out_valid), 64'd0);

    for (int i = 0; i < 300; i++) begin
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 4) == 0) b = b & 32'h0000_00FF;
      issue(op, a, b);
    end
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
